// File: rtl/shifter_pkg.sv
// Shared definitions for the serial right shifter.
package shifter_pkg;

  // FSM states of the iterative shifter
  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    DONE  = 2'b10
  } shifter_state_t;

  // Encoding of the arith request bit
  localparam logic SHIFT_FILL_LOGICAL = 1'b0;
  localparam logic SHIFT_FILL_ARITH   = 1'b1;

endpackage : shifter_pkg

// File: rtl/nbit_shift_right_by1.sv
// Combinational one-position right shift with an explicit fill bit.
module nbit_shift_right_by1 #(
  parameter int unsigned N = 32
) (
  input  logic [N-1:0] a,
  input  logic         fill,
  output logic [N-1:0] y_c
);

  // Drop the LSB and insert the fill bit at the top
  always_comb begin
    y_c = {fill, a[N-1:1]};
  end

endmodule : nbit_shift_right_by1

// File: rtl/nbit_serial_right_shifter.sv
// Iterative SRL/SRA shifter: one bit position per clock, done pulse on completion.
module nbit_serial_right_shifter
  import shifter_pkg::*;
#(
  parameter int unsigned N   = 32,
  parameter int unsigned SHW = $clog2(N)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic           arith,
  input  logic [N-1:0]   a,
  input  logic [SHW-1:0] shamt,
  input  logic           flush,
  output logic           busy,
  output logic           done,
  output logic [N-1:0]   result
);

  shifter_state_t state;
  shifter_state_t state_next;
  logic [SHW-1:0] cnt;
  logic [SHW-1:0] cnt_next;
  logic           fill_bit;
  logic           fill_next;
  logic [N-1:0]   result_next;
  logic [N-1:0]   shifted_c;

  nbit_shift_right_by1 #(
    .N (N)
  ) u_by1 (
    .a    (result),
    .fill (fill_bit),
    .y_c  (shifted_c)
  );

  // Next-state and datapath control; flush overrides every state
  always_comb begin
    state_next  = state;
    cnt_next    = cnt;
    fill_next   = fill_bit;
    result_next = result;
    if (flush) begin
      state_next  = IDLE;
      cnt_next    = '0;
      result_next = '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            result_next = a;
            cnt_next    = shamt;
            // Sign is latched once so the fill cannot change mid-operation
            fill_next   = (arith == SHIFT_FILL_ARITH) ? a[N-1] : 1'b0;
            state_next  = (shamt != '0) ? SHIFT : DONE;
          end
        end
        SHIFT: begin
          result_next = shifted_c;
          cnt_next    = cnt - SHW'(1);
          if (cnt == SHW'(1)) begin
            state_next = DONE;
          end
        end
        DONE: begin
          state_next = IDLE;
        end
        default: begin
          state_next = IDLE;
        end
      endcase
    end
  end

  // State and datapath registers; busy/done registered from the next state
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      fill_bit <= 1'b0;
      result   <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      state    <= state_next;
      cnt      <= cnt_next;
      fill_bit <= fill_next;
      result   <= result_next;
      busy     <= (state_next == SHIFT);
      done     <= (state_next == DONE);
    end
  end

endmodule : nbit_serial_right_shifter

// File: tb/tb_nbit_serial_right_shifter.sv
// Directed self-checking bench for nbit_serial_right_shifter (N=32).
module tb_nbit_serial_right_shifter;

  localparam int unsigned N   = 32;
  localparam int unsigned SHW = 5;

  logic           clk = 1'b0;
  logic           rst;
  logic           start;
  logic           arith;
  logic           flush;
  logic [N-1:0]   a;
  logic [SHW-1:0] shamt;
  logic           busy;
  logic           done;
  logic [N-1:0]   result;

  int n_checks = 0;
  int n_fail   = 0;

  nbit_serial_right_shifter #(.N(N)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .arith  (arith),
    .a      (a),
    .shamt  (shamt),
    .flush  (flush),
    .busy   (busy),
    .done   (done),
    .result (result)
  );

  always #5 clk = ~clk;

  // Advance one clock; outputs are sampled 1ns after the rising edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; flush = 1'b0; arith = 1'b0; a = '0; shamt = '0;
    step(); step();
    rst = 1'b0;
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b exp=0", busy); end
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done got=%b exp=0", done); end
    n_checks++; if (result !== 32'h0) begin n_fail++; $display("FAIL reset_result got=%h exp=0", result); end
    a = 32'hDEAD_BEEF; shamt = 5'd3;
    step();
    n_checks++; if (result !== 32'h0 || busy !== 1'b0) begin n_fail++; $display("FAIL idle_hold result=%h busy=%b exp 0/0", result, busy); end
  endtask

  // Plain shifts of several lengths and both fill modes
  task automatic test_shift_ops();
    logic [N-1:0]   va [5] = '{32'h8000_00F0, 32'h8000_00F0, 32'h1234_5678, 32'h8000_0000, 32'h8000_0000};
    logic [SHW-1:0] sa [5] = '{5'd4, 5'd4, 5'd0, 5'd31, 5'd31};
    logic           ar [5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    logic [N-1:0]   ex [5] = '{32'h0800_000F, 32'hF800_000F, 32'h1234_5678, 32'hFFFF_FFFF, 32'h0000_0001};
    for (int i = 0; i < 5; i++) begin
      a = va[i]; shamt = sa[i]; arith = ar[i]; start = 1'b1;
      for (int cyc = 1; cyc <= int'(sa[i]) + 1; cyc++) begin
        step();
        if (cyc == 1) begin
          start = 1'b0; a = ~va[i]; arith = ~ar[i];
        end
        n_checks++;
        if (busy !== 1'(cyc <= int'(sa[i]))) begin
          n_fail++; $display("FAIL op%0d_busy cyc=%0d got=%b exp=%b", i, cyc, busy, 1'(cyc <= int'(sa[i])));
        end
        n_checks++;
        if (done !== 1'(cyc == int'(sa[i]) + 1)) begin
          n_fail++; $display("FAIL op%0d_done cyc=%0d got=%b exp=%b", i, cyc, done, 1'(cyc == int'(sa[i]) + 1));
        end
        if (cyc == int'(sa[i]) + 1) begin
          n_checks++;
          if (result !== ex[i]) begin n_fail++; $display("FAIL op%0d_result got=%h exp=%h", i, result, ex[i]); end
        end
      end
      step();
      n_checks++;
      if (done !== 1'b0 || result !== ex[i]) begin
        n_fail++; $display("FAIL op%0d_after done=%b result=%h exp 0/%h", i, done, result, ex[i]);
      end
    end
  endtask

  // Flush mid-shift, then an immediate new request
  task automatic test_flush();
    a = 32'hFFFF_0000; shamt = 5'd10; arith = 1'b0; start = 1'b1;
    for (int cyc = 1; cyc <= 3; cyc++) begin
      step();
      start = 1'b0;
      n_checks++;
      if (busy !== 1'b1 || done !== 1'b0) begin n_fail++; $display("FAIL flush_pre cyc=%0d busy=%b done=%b exp 1/0", cyc, busy, done); end
    end
    flush = 1'b1;
    step();
    flush = 1'b0;
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL flush_busy got=%b exp=0", busy); end
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL flush_done got=%b exp=0", done); end
    n_checks++; if (result !== 32'h0) begin n_fail++; $display("FAIL flush_result got=%h exp=0", result); end
    a = 32'h0000_00F0; shamt = 5'd4; start = 1'b1;
    for (int cyc = 1; cyc <= 5; cyc++) begin
      step();
      start = 1'b0;
      n_checks++;
      if (done !== 1'(cyc == 5) || busy !== 1'(cyc <= 4)) begin
        n_fail++; $display("FAIL flush_restart cyc=%0d busy=%b done=%b", cyc, busy, done);
      end
    end
    n_checks++; if (result !== 32'h0000_000F) begin n_fail++; $display("FAIL flush_restart_result got=%h exp=0000000f", result); end
    step();
  endtask

  // start during SHIFT and DONE must be ignored
  task automatic test_ignore_start();
    a = 32'h0000_FF00; shamt = 5'd8; arith = 1'b0; start = 1'b1;
    step();
    a = 32'hFFFF_FFFF; shamt = 5'd1; arith = 1'b1;
    for (int cyc = 2; cyc <= 9; cyc++) begin
      step();
      n_checks++;
      if (done !== 1'(cyc == 9) || busy !== 1'(cyc <= 8)) begin
        n_fail++; $display("FAIL ignore cyc=%0d busy=%b done=%b", cyc, busy, done);
      end
    end
    n_checks++; if (result !== 32'h0000_00FF) begin n_fail++; $display("FAIL ignore_result got=%h exp=000000ff", result); end
    step();
    start = 1'b0;
    n_checks++;
    if (busy !== 1'b0 || done !== 1'b0 || result !== 32'h0000_00FF) begin
      n_fail++; $display("FAIL ignore_in_done busy=%b done=%b result=%h exp 0/0/000000ff", busy, done, result);
    end
    step();
  endtask

  // Synchronous reset in the middle of an operation
  task automatic test_reset_mid();
    a = 32'hDEAD_BEEF; shamt = 5'd8; arith = 1'b1; start = 1'b1;
    step();
    start = 1'b0;
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int cyc = 3; cyc <= 11; cyc++) begin
      n_checks++;
      if (busy !== 1'b0 || done !== 1'b0 || result !== 32'h0) begin
        n_fail++; $display("FAIL reset_mid cyc=%0d busy=%b done=%b result=%h exp 0/0/0", cyc, busy, done, result);
      end
      step();
    end
  endtask

  // flush wins over start in IDLE
  task automatic test_flush_start();
    a = 32'h1234_5678; shamt = 5'd0; arith = 1'b0; start = 1'b1; flush = 1'b1;
    step();
    start = 1'b0; flush = 1'b0;
    n_checks++;
    if (done !== 1'b0 || busy !== 1'b0 || result !== 32'h0) begin
      n_fail++; $display("FAIL flush_start_a done=%b busy=%b result=%h exp 0/0/0", done, busy, result);
    end
    shamt = 5'd3; start = 1'b1; flush = 1'b1;
    step();
    start = 1'b0; flush = 1'b0;
    step();
    n_checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      n_fail++; $display("FAIL flush_start_b busy=%b done=%b exp 0/0", busy, done);
    end
  endtask

  // Two requests separated by the minimum single IDLE cycle
  task automatic test_back_to_back();
    a = 32'h0000_00F0; shamt = 5'd1; arith = 1'b0; start = 1'b1;
    step();
    start = 1'b0;
    step();
    n_checks++;
    if (done !== 1'b1 || result !== 32'h0000_0078) begin
      n_fail++; $display("FAIL b2b_first done=%b result=%h exp 1/00000078", done, result);
    end
    step();
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL b2b_gap done=%b exp=0", done); end
    a = 32'h8000_0001; shamt = 5'd1; arith = 1'b1; start = 1'b1;
    step();
    start = 1'b0;
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL b2b_busy got=%b exp=1", busy); end
    step();
    n_checks++;
    if (done !== 1'b1 || result !== 32'hC000_0000) begin
      n_fail++; $display("FAIL b2b_second done=%b result=%h exp 1/c0000000", done, result);
    end
    step();
  endtask

  initial begin
    test_reset();
    test_shift_ops();
    test_flush();
    test_ignore_start();
    test_reset_mid();
    test_flush_start();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

endmodule : tb_nbit_serial_right_shifter
